// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor 0 for the 5-stage pipeline.
// Holds SR, Cause, EPC and PRId. It serves mfc0/mtc0 from the M stage and
// arbitrates hardware interrupts against M-stage exceptions. It also answers
// the D-stage eret handshake through EXLClr and the (bypassed) EPC output.
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h1606_1001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        We,
  input  logic [31:0] PC_M,
  input  logic        Valid_M,
  input  logic        BD_M,
  input  logic [4:0]  ExcCode_M,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] DOut,
  output logic        EXL
);

  localparam logic [4:0] IDX_SR    = 5'd12;
  localparam logic [4:0] IDX_CAUSE = 5'd13;
  localparam logic [4:0] IDX_EPC   = 5'd14;
  localparam logic [4:0] IDX_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im_reg, im_next;
  logic        exl_reg, exl_next;
  logic        ie_reg, ie_next;
  // Cause fields
  logic        bd_reg, bd_next;
  logic [5:0]  ip_reg, ip_next;
  logic [4:0]  exc_reg, exc_next;
  // EPC is always word aligned, so only the word address is stored
  logic [29:0] epc_reg, epc_next;

  logic [5:0]  int_pend;
  logic        int_req;
  logic        exc_req;
  logic        take_req;
  logic [29:0] pc_word;
  logic        unused_pc_bits;

  // The byte offset of the M-stage PC never reaches EPC
  assign pc_word        = PC_M[31:2];
  assign unused_pc_bits = ^PC_M[1:0];

  // A hardware line is pending only when its IM bit unmasks it
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_pend
      assign int_pend[gi] = HWInt[gi] & im_reg[gi];
    end
  endgenerate

  // Gating by Valid_M defers a request across bubbles instead of losing it,
  // because nothing is latched until a real instruction reaches M.
  assign int_req  = (|int_pend) & ie_reg & ~exl_reg & Valid_M;
  assign exc_req  = (ExcCode_M != 5'd0) & ~exl_reg & Valid_M;
  assign take_req = int_req | exc_req;

  assign IntReq = take_req;
  assign EXL    = exl_reg;

  // EPC forwards an mtc0 EPC in M, so a D-stage eret needs no stall
  always_comb begin
    EPC = {epc_reg, 2'b00};
    if (We && (A2 == IDX_EPC)) begin
      EPC = {DIn[31:2], 2'b00};
    end
  end

  // mfc0 read mux from the registered state only (no bypass)
  always_comb begin
    DOut = 32'd0;
    case (A1)
      IDX_SR:    DOut = {16'd0, im_reg, 8'd0, exl_reg, ie_reg};
      IDX_CAUSE: DOut = {bd_reg, 15'd0, ip_reg, 3'd0, exc_reg, 2'b00};
      IDX_EPC:   DOut = {epc_reg, 2'b00};
      IDX_PRID:  DOut = PRID;
      default:   DOut = 32'd0;
    endcase
  end

  // Next-state logic: taking an exception overrides any mtc0 in the same
  // cycle; otherwise mtc0 applies first and eret then wins on EXL.
  always_comb begin
    im_next  = im_reg;
    exl_next = exl_reg;
    ie_next  = ie_reg;
    bd_next  = bd_reg;
    ip_next  = HWInt;
    exc_next = exc_reg;
    epc_next = epc_reg;
    if (take_req) begin
      exl_next = 1'b1;
      exc_next = int_req ? 5'd0 : ExcCode_M;
      bd_next  = BD_M;
      // Word arithmetic is the same as subtracting 4 modulo 2^32
      epc_next = BD_M ? (pc_word - 30'd1) : pc_word;
    end else begin
      if (We) begin
        case (A2)
          IDX_SR: begin
            im_next  = DIn[15:10];
            exl_next = DIn[1];
            ie_next  = DIn[0];
          end
          IDX_EPC: epc_next = DIn[31:2];
          default: ;
        endcase
      end
      if (EXLClr) begin
        exl_next = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_reg  <= 6'd0;
      exl_reg <= 1'b0;
      ie_reg  <= 1'b0;
      bd_reg  <= 1'b0;
      ip_reg  <= 6'd0;
      exc_reg <= 5'd0;
      epc_reg <= 30'd0;
    end else begin
      im_reg  <= im_next;
      exl_reg <= exl_next;
      ie_reg  <= ie_next;
      bd_reg  <= bd_next;
      ip_reg  <= ip_next;
      exc_reg <= exc_next;
      epc_reg <= epc_next;
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Testbench for cp0_unit: directed vectors; each step pushes its expected
// outputs into a scoreboard queue tagged with the cycle, and a monitor
// process on the falling edge pops and compares them against the DUT.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h1606_1001;
  localparam int SIG_INTREQ = 0;
  localparam int SIG_EPC    = 1;
  localparam int SIG_DOUT   = 2;
  localparam int SIG_EXL    = 3;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        We;
  logic [31:0] PC_M;
  logic        Valid_M;
  logic        BD_M;
  logic [4:0]  ExcCode_M;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] DOut;
  logic        EXL;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc_cnt;
  int   n_cmp;
  int   n_bad;
  bit   stim_done;

  cp0_unit #(.PRID(PRID)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .We(We),
    .PC_M(PC_M), .Valid_M(Valid_M), .BD_M(BD_M), .ExcCode_M(ExcCode_M),
    .HWInt(HWInt), .EXLClr(EXLClr), .IntReq(IntReq), .EPC(EPC),
    .DOut(DOut), .EXL(EXL)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Advance to just after the next rising edge, with strobes idle
  task automatic step();
    @(posedge clk);
    #1;
    We      = 1'b0;
    EXLClr  = 1'b0;
  endtask

  task automatic expect_sig(input string name, input int sig, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = exp;
    e.cyc  = cyc_cnt;
    q.push_back(e);
  endtask

  // Monitor: compares every expectation due in the current cycle
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
        e = q.pop_front();
        case (e.sig)
          SIG_INTREQ: act = {31'd0, IntReq};
          SIG_EPC:    act = EPC;
          SIG_DOUT:   act = DOut;
          default:    act = {31'd0, EXL};
        endcase
        n_cmp++;
        if (e.cyc != cyc_cnt || act !== e.exp) begin
          n_bad++;
          $display("FAIL %s cyc=%0d: got 0x%08h, expected 0x%08h (due cyc %0d)",
                   e.name, cyc_cnt, act, e.exp, e.cyc);
        end else begin
          $display("ok   %s cyc=%0d: 0x%08h", e.name, cyc_cnt, act);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc_cnt = 0; n_cmp = 0; n_bad = 0; stim_done = 0;
    reset = 1'b0; A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; We = 1'b0;
    PC_M = 32'd0; Valid_M = 1'b0; BD_M = 1'b0; ExcCode_M = 5'd0;
    HWInt = 6'd0; EXLClr = 1'b0;

    // Held in reset
    step();
    A1 = 5'd15;
    expect_sig("rst_prid", SIG_DOUT, PRID);
    expect_sig("rst_exl", SIG_EXL, 32'd0);
    expect_sig("rst_epc", SIG_EPC, 32'd0);
    expect_sig("rst_intreq", SIG_INTREQ, 32'd0);

    // Release reset
    step(); reset = 1'b1; A1 = 5'd12;
    expect_sig("rst_sr", SIG_DOUT, 32'd0);

    // mtc0 SR = 0x401 (IM[0], IE)
    step(); We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401; A1 = 5'd12;
    expect_sig("sr_no_bypass", SIG_DOUT, 32'd0);
    expect_sig("sr_wr_noreq", SIG_INTREQ, 32'd0);

    // Interrupt on HWInt[0]
    step(); A1 = 5'd12; HWInt = 6'b000001; Valid_M = 1'b1; PC_M = 32'h3008;
    expect_sig("sr_read", SIG_DOUT, 32'h0000_0401);
    expect_sig("int_req", SIG_INTREQ, 32'd1);

    step(); A1 = 5'd13;
    expect_sig("int_masked", SIG_INTREQ, 32'd0);
    expect_sig("int_exl", SIG_EXL, 32'd1);
    expect_sig("int_epc", SIG_EPC, 32'h3008);
    expect_sig("int_cause", SIG_DOUT, 32'h0000_0400);

    // eret clears EXL on the edge, not before
    step(); EXLClr = 1'b1; Valid_M = 1'b0; A1 = 5'd12;
    expect_sig("eret_noreq", SIG_INTREQ, 32'd0);
    expect_sig("eret_sr", SIG_DOUT, 32'h0000_0403);

    // Interrupt beats exception in the delay slot
    step(); Valid_M = 1'b1; ExcCode_M = 5'd4; BD_M = 1'b1; PC_M = 32'h300C;
    expect_sig("prio_exl0", SIG_EXL, 32'd0);
    expect_sig("prio_req", SIG_INTREQ, 32'd1);

    step(); Valid_M = 1'b0; ExcCode_M = 5'd0; BD_M = 1'b0; HWInt = 6'd0; A1 = 5'd13;
    expect_sig("prio_cause", SIG_DOUT, 32'h8000_0400);
    expect_sig("prio_epc", SIG_EPC, 32'h3008);

    step(); EXLClr = 1'b1; A1 = 5'd13;
    expect_sig("ip_follow", SIG_DOUT, 32'h8000_0000);

    // Exception deferred across two bubbles
    step(); ExcCode_M = 5'd8; Valid_M = 1'b0;
    expect_sig("defer1", SIG_INTREQ, 32'd0);
    expect_sig("defer_exl0", SIG_EXL, 32'd0);
    step();
    expect_sig("defer2", SIG_INTREQ, 32'd0);
    step(); Valid_M = 1'b1; PC_M = 32'h3020;
    expect_sig("defer_take", SIG_INTREQ, 32'd1);

    step(); Valid_M = 1'b0; ExcCode_M = 5'd0; A1 = 5'd13;
    expect_sig("exc_epc", SIG_EPC, 32'h3020);
    expect_sig("exc_cause", SIG_DOUT, 32'h0000_0020);

    // mtc0 EPC bypass with eret in the same cycle
    step(); We = 1'b1; A2 = 5'd14; DIn = 32'h0000_3041; EXLClr = 1'b1; A1 = 5'd14;
    expect_sig("byp_epc", SIG_EPC, 32'h3040);
    expect_sig("byp_dout", SIG_DOUT, 32'h3020);
    expect_sig("byp_exl", SIG_EXL, 32'd1);

    step(); A1 = 5'd14;
    expect_sig("byp_exl_clr", SIG_EXL, 32'd0);
    expect_sig("byp_epc_reg", SIG_DOUT, 32'h3040);

    // mtc0 SR dropped when an exception is taken; EXLClr loses too
    step(); Valid_M = 1'b1; ExcCode_M = 5'd10; PC_M = 32'h3050;
    We = 1'b1; A2 = 5'd12; DIn = 32'd0; EXLClr = 1'b1;
    expect_sig("mtc_exc_req", SIG_INTREQ, 32'd1);

    step(); Valid_M = 1'b0; ExcCode_M = 5'd0; A1 = 5'd12;
    expect_sig("mtc_drop_sr", SIG_DOUT, 32'h0000_0403);
    expect_sig("mtc_drop_exl", SIG_EXL, 32'd1);
    expect_sig("mtc_drop_epc", SIG_EPC, 32'h3050);

    step(); A1 = 5'd15;
    expect_sig("prid", SIG_DOUT, PRID);

    // mtc0 SR with EXL=1 plus eret: EXLClr wins on EXL
    step(); A1 = 5'd7; We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0003; EXLClr = 1'b1;
    expect_sig("idx7", SIG_DOUT, 32'd0);

    step(); A1 = 5'd12;
    expect_sig("exlclr_wins", SIG_DOUT, 32'h0000_0001);

    // Set EXL=1, EPC=0x3010, then reset mid-run
    step(); Valid_M = 1'b1; ExcCode_M = 5'd4; PC_M = 32'h3010;
    expect_sig("pre_rst_req", SIG_INTREQ, 32'd1);
    step(); Valid_M = 1'b0; ExcCode_M = 5'd0; HWInt = 6'b000001;
    expect_sig("pre_rst_exl", SIG_EXL, 32'd1);
    expect_sig("pre_rst_epc", SIG_EPC, 32'h3010);
    step(); reset = 1'b0; A1 = 5'd13;
    expect_sig("async_exl", SIG_EXL, 32'd0);
    expect_sig("async_epc", SIG_EPC, 32'd0);
    expect_sig("async_cause", SIG_DOUT, 32'd0);

    step(); reset = 1'b1; HWInt = 6'd0; Valid_M = 1'b1; ExcCode_M = 5'd0;
    expect_sig("post_rst_req", SIG_INTREQ, 32'd0);

    step(); Valid_M = 1'b0;
    step();
    step();
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
